rca_wide_add_seq: RTL and testbench
===================================

// Module: rca_wide_add_seq
// PURPOSE
//   Word-serial sequencer that reuses one external WIDTH-bit ripple-carry adder to compute WIDTH*WORDS-bit add/subtract.
//   It latches wide operands on start, feeds one word per cycle (LSW first) to the shared adder and chains the carry through a register.
//   It reports a wide result, carry-out and signed overflow via a start/busy/done handshake.
//   Sits between the control logic and the RCA_16bit datapath instance.
// PARAMETERS
//   WIDTH  16  width of the external adder (bits per word)
//   WORDS  4   number of words per operand (total width N = WIDTH*WORDS, WORDS >= 2)
// PORTS
//   clk        in   1          single clock, all state updates on rising edge
//   rst        in   1          synchronous, active-high reset
//   start      in   1          request; sampled only in IDLE
//   sub        in   1          0: A+B+cin, 1: A-B (B inverted, cin forced 1)
//   cin        in   1          carry-in for add mode; ignored when sub=1
//   op_a       in   N          operand A, latched on accepted start
//   op_b       in   N          operand B, latched on accepted start
//   adder_a    out  WIDTH      to external adder input a
//   adder_b    out  WIDTH      to external adder input b
//   adder_cin  out  1          to external adder carry-in
//   adder_sum  in   WIDTH      from external adder sum (combinational)
//   adder_cout in   1          from external adder carry-out
//   busy       out  1          high while in RUN
//   done       out  1          one-cycle pulse, result valid
//   result     out  N          wide sum/difference, held until next accepted start
//   cout       out  1          final carry-out (sub: 1 = no borrow)
//   ovf        out  1          signed overflow of the N-bit operation
// BEHAVIOUR
//   Reset: state=IDLE; busy, done, cout, ovf, adder_a, adder_b and adder_cin are 0; result=0; idx=0; carry_reg=0.
//   States:
//     IDLE: start=1 latches A, B_eff=sub?~op_b:op_b, c0=sub?1:cin, clears result, then goes to RUN with idx=0.
//     RUN: adder_a=A[idx], adder_b=B_eff[idx], adder_cin=(idx==0)?c0:carry_reg.
//       Each edge: result word idx<=adder_sum, carry_reg<=adder_cout, idx++.
//       On the edge with idx==WORDS-1: cout<=adder_cout, ovf<=(A_msb==B_eff_msb)&&(adder_sum msb!=A_msb), then go to DONE.
//     DONE: done=1 for exactly this cycle, busy=0, then go to IDLE.
//   Latency:
//     start sampled at edge E0; busy high for cycles E0..E_WORDS; done high in the cycle after edge E_WORDS (WORDS+1 cycles after E0).
//     Throughput is one operation per WORDS+2 cycles.
//   Outside RUN, adder_a, adder_b and adder_cin are driven to 0.
//   start is ignored in RUN and DONE; there is no queueing, and operands must be re-presented.
//   op_a, op_b, sub and cin may change freely after acceptance; the latched copies are used.
//   result is partially updated during RUN; it is only guaranteed valid from the done cycle until the next accepted start.
//   Carry between words propagates only via carry_reg; there is no combinational path from start or op_* to the adder.
//   rst mid-RUN or DONE: next cycle IDLE with reset values, and done is never pulsed for the aborted operation.
//   rst has priority over start on the same edge.
// TESTING (WIDTH=16, WORDS=4)
//   1. Hold rst 2 cycles -> busy=done=cout=ovf=0, result=0, adder_*=0; release, no start -> stays idle.
//   2. Add: A=64'h0000_0000_0000_FFFF, B=64'h1, cin=0.
//      -> result=64'h0000_0000_0001_0000, cout=0, ovf=0.
//      -> done exactly 5 cycles after the start edge; busy high for 4 cycles.
//   3. Full carry chain: A=64'hFFFF_FFFF_FFFF_FFFF, B=0, cin=1 -> result=0, cout=1, ovf=0.
//      adder_cin=1 observed on every RUN cycle.
//   4. Subtract:
//      A=5, B=7, sub=1 -> result=64'hFFFF_FFFF_FFFF_FFFE, cout=0, ovf=0.
//      A=64'h8000_0000_0000_0000, B=1, sub=1 -> result=64'h7FFF_FFFF_FFFF_FFFF, cout=1, ovf=1.
//   5. Start A=1, B=2; re-pulse start with A=100, B=100 during busy -> second start ignored, result=3, single done pulse.
//   6. Start, assert rst on the 2nd RUN cycle -> IDLE next cycle, no done pulse.
//      A new start then completes normally with the correct result.

Source files
------------

// File: rtl/rca_wide_add_seq_if.sv
// Bundle between the control logic, the wide-add sequencer and the shared word-wide adder.
// The master is the control/adder side and the slave is the sequencer.
interface rca_wide_add_seq_if #(
    parameter int WIDTH = 16,
    parameter int WORDS = 4
);
    localparam int N = WIDTH * WORDS;

    logic             start;
    logic             sub;
    logic             cin;
    logic [N-1:0]     op_a;
    logic [N-1:0]     op_b;
    logic             busy;
    logic             done;
    logic [N-1:0]     result;
    logic             cout;
    logic             ovf;
    logic [WIDTH-1:0] adder_a;
    logic [WIDTH-1:0] adder_b;
    logic             adder_cin;
    logic [WIDTH-1:0] adder_sum;
    logic             adder_cout;

    modport slave (
        input  start, sub, cin, op_a, op_b, adder_sum, adder_cout,
        output busy, done, result, cout, ovf, adder_a, adder_b, adder_cin
    );

    modport master (
        output start, sub, cin, op_a, op_b, adder_sum, adder_cout,
        input  busy, done, result, cout, ovf, adder_a, adder_b, adder_cin
    );
endinterface

// File: rtl/rca_wide_add_seq.sv
// Word-serial wide add/subtract: one WIDTH-bit external adder is reused for WORDS cycles,
// LSW first, with the inter-word carry held in a register.
module rca_wide_add_seq #(
    parameter int WIDTH = 16,
    parameter int WORDS = 4
) (
    input logic            clk,
    input logic            rst,
    rca_wide_add_seq_if.slave bus
);
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                        r_state;
    state_t                        w_next;
    logic [IDX_W-1:0]              r_idx;
    logic [WORDS-1:0][WIDTH-1:0]   r_a;
    logic [WORDS-1:0][WIDTH-1:0]   r_b;
    logic [WORDS-1:0][WIDTH-1:0]   r_result;
    logic                          r_c0;
    logic                          r_carry;
    logic                          r_cout;
    logic                          r_ovf;
    logic                          w_last;
    logic                          w_ovf;

    assign w_last = (r_idx == LAST_IDX);
    // Signed overflow: operand signs agree but the top word's sum sign differs.
    assign w_ovf  = (r_a[WORDS-1][WIDTH-1] == r_b[WORDS-1][WIDTH-1]) &&
                    (bus.adder_sum[WIDTH-1] != r_a[WORDS-1][WIDTH-1]);

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_next = RUN;
            RUN:     if (w_last) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // The adder sees only registered operands, never start or op_* directly.
    always_comb begin
        bus.adder_a   = '0;
        bus.adder_b   = '0;
        bus.adder_cin = 1'b0;
        if (r_state == RUN) begin
            bus.adder_a   = r_a[r_idx];
            bus.adder_b   = r_b[r_idx];
            bus.adder_cin = (r_idx == '0) ? r_c0 : r_carry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx    <= '0;
            r_c0     <= 1'b0;
            r_carry  <= 1'b0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
            r_result <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_a      <= bus.op_a;
                        r_b      <= bus.sub ? ~bus.op_b : bus.op_b;
                        r_c0     <= bus.sub ? 1'b1 : bus.cin;
                        r_result <= '0;
                        r_idx    <= '0;
                        r_carry  <= 1'b0;
                    end
                end
                RUN: begin
                    r_result[r_idx] <= bus.adder_sum;
                    r_carry         <= bus.adder_cout;
                    if (w_last) begin
                        r_idx  <= '0;
                        r_cout <= bus.adder_cout;
                        r_ovf  <= w_ovf;
                    end else begin
                        r_idx  <= r_idx + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy   = (r_state == RUN);
    assign bus.done   = (r_state == DONE);
    assign bus.result = r_result;
    assign bus.cout   = r_cout;
    assign bus.ovf    = r_ovf;
endmodule

// File: tb/tb_rca_wide_add_seq.sv
// Bench for rca_wide_add_seq (WIDTH=16, WORDS=4) with a behavioural model of the external adder.
module tb_rca_wide_add_seq;
    localparam int WIDTH = 16;
    localparam int WORDS = 4;
    localparam int N     = WIDTH * WORDS;

    logic clk;
    logic rst;

    rca_wide_add_seq_if #(.WIDTH(WIDTH), .WORDS(WORDS)) bus ();

    rca_wide_add_seq #(.WIDTH(WIDTH), .WORDS(WORDS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // External 16-bit ripple-carry adder, purely combinational.
    logic [WIDTH:0] adder_full;
    always_comb begin
        adder_full     = {1'b0, bus.adder_a} + {1'b0, bus.adder_b} + {{WIDTH{1'b0}}, bus.adder_cin};
        bus.adder_sum  = adder_full[WIDTH-1:0];
        bus.adder_cout = adder_full[WIDTH];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Observations of the most recent operation; k counts falling edges after the start edge.
    logic [N-1:0] o_res_first, o_res_done, o_res_end;
    logic         o_cout, o_ovf, o_cin_all, o_busy_after_rst;
    int           o_done_k, o_done_cnt, o_busy_cnt;

    task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic s, input logic c,
                         input int restart_at, input int rst_at);
        @(negedge clk);
        bus.op_a  = a;
        bus.op_b  = b;
        bus.sub   = s;
        bus.cin   = c;
        bus.start = 1'b1;
        o_res_first = 'x; o_res_done = 'x; o_res_end = 'x;
        o_cout = 1'bx; o_ovf = 1'bx; o_cin_all = 1'b1; o_busy_after_rst = 1'bx;
        o_done_k = 0; o_done_cnt = 0; o_busy_cnt = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) o_res_first = bus.result;
            if (bus.busy) begin
                o_busy_cnt++;
                o_cin_all = o_cin_all & bus.adder_cin;
            end
            if (bus.done) begin
                o_done_cnt++;
                if (o_done_k == 0) begin
                    o_done_k   = k;
                    o_res_done = bus.result;
                    o_cout     = bus.cout;
                    o_ovf      = bus.ovf;
                end
            end
            if (rst_at != 0 && k == rst_at + 1) o_busy_after_rst = bus.busy;
            if (k == 10) o_res_end = bus.result;
            // drive the next cycle's inputs
            bus.start = 1'b0;
            bus.op_a  = ~a;
            bus.op_b  = ~b;
            bus.sub   = ~s;
            bus.cin   = ~c;
            if (restart_at != 0 && k == restart_at) begin
                bus.start = 1'b1;
                bus.op_a  = 64'd100;
                bus.op_b  = 64'd100;
                bus.sub   = 1'b0;
                bus.cin   = 1'b0;
            end
            rst = (rst_at != 0 && k == rst_at);
        end
    endtask

    typedef struct {
        string        name;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic         s;
        logic         c;
        logic [N-1:0] r;
        logic         co;
        logic         ov;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{"add_word_carry", 64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0,
                    64'h0000_0000_0001_0000, 1'b0, 1'b0};
        vecs[1] = '{"full_chain", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b0, 1'b1,
                    64'h0, 1'b1, 1'b0};
        vecs[2] = '{"sub_neg", 64'd5, 64'd7, 1'b1, 1'b0,
                    64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
        vecs[3] = '{"sub_ovf", 64'h8000_0000_0000_0000, 64'h1, 1'b1, 1'b0,
                    64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
        vecs[4] = '{"add_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0,
                    64'h8000_0000_0000_0000, 1'b0, 1'b1};
        vecs[5] = '{"add_cin", 64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0, 1'b1,
                    64'h2345_6789_ABCD_F002, 1'b0, 1'b0};
        vecs[6] = '{"sub_cin_ignored", 64'd10, 64'd3, 1'b1, 1'b0,
                    64'd7, 1'b1, 1'b0};
        vecs[7] = '{"add_cout", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0,
                    64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0};

        rst = 1'b1;
        bus.start = 1'b0; bus.sub = 1'b0; bus.cin = 1'b0;
        bus.op_a = '0; bus.op_b = '0;
        repeat (2) @(negedge clk);
        check("rst_busy",   N'(bus.busy),      N'(0));
        check("rst_done",   N'(bus.done),      N'(0));
        check("rst_cout",   N'(bus.cout),      N'(0));
        check("rst_ovf",    N'(bus.ovf),       N'(0));
        check("rst_result", bus.result,        N'(0));
        check("rst_adder_a",   N'(bus.adder_a),   N'(0));
        check("rst_adder_b",   N'(bus.adder_b),   N'(0));
        check("rst_adder_cin", N'(bus.adder_cin), N'(0));
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_busy", N'(bus.busy), N'(0));
        check("idle_done", N'(bus.done), N'(0));

        for (int i = 0; i < 8; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].c, 0, 0);
            check({vecs[i].name, "_cleared"},  o_res_first,       N'(0));
            check({vecs[i].name, "_result"},   o_res_done,        vecs[i].r);
            check({vecs[i].name, "_cout"},     N'(o_cout),        N'(vecs[i].co));
            check({vecs[i].name, "_ovf"},      N'(o_ovf),         N'(vecs[i].ov));
            check({vecs[i].name, "_done_lat"}, N'(o_done_k),      N'(5));
            check({vecs[i].name, "_done_cnt"}, N'(o_done_cnt),    N'(1));
            check({vecs[i].name, "_busy_cnt"}, N'(o_busy_cnt),    N'(4));
            check({vecs[i].name, "_held"},     o_res_end,         vecs[i].r);
            if (i == 1) check("full_chain_adder_cin", N'(o_cin_all), N'(1));
        end

        // second start while busy must be ignored
        do_op(64'd1, 64'd2, 1'b0, 1'b0, 2, 0);
        check("restart_result",   o_res_done,     N'(3));
        check("restart_done_cnt", N'(o_done_cnt), N'(1));
        check("restart_done_lat", N'(o_done_k),   N'(5));
        check("restart_held",     o_res_end,      N'(3));

        // reset in the second RUN cycle aborts without a done pulse
        do_op(64'h1234, 64'h4321, 1'b0, 1'b0, 0, 2);
        check("abort_busy_next", N'(o_busy_after_rst), N'(0));
        check("abort_done_cnt",  N'(o_done_cnt),       N'(0));
        check("abort_result",    o_res_end,            N'(0));
        check("abort_cout",      N'(bus.cout),         N'(0));

        do_op(64'hFFFF_0000_FFFF_0000, 64'h0001_0000_0001_0000, 1'b0, 1'b0, 0, 0);
        check("after_abort_result", o_res_done,     64'h0000_0001_0000_0000);
        check("after_abort_cout",   N'(o_cout),     N'(1));
        check("after_abort_ovf",    N'(o_ovf),      N'(0));
        check("after_abort_lat",    N'(o_done_k),   N'(5));

        @(negedge clk);
        check("final_idle_adder_a", N'(bus.adder_a), N'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
